// File: rtl/sd_sector_read_arbiter_pkg.sv
// Shared definitions for the SD sector-read path: reader card_stat codes,
// card-type codes and the arbiter state encoding.
package sd_sector_read_arbiter_pkg;

  typedef enum logic [3:0] {
    CS_RESET      = 4'd0,
    CS_CMD0       = 4'd1,
    CS_CMD8       = 4'd2,
    CS_CMD1       = 4'd3,
    CS_CMD8FAILED = 4'd4,
    CS_ACMD41     = 4'd5,
    CS_CMD58      = 4'd6,
    CS_CMD16      = 4'd7,
    CS_IDLE       = 4'd8,
    CS_READING    = 4'd9
  } card_stat_e;

  typedef enum logic [1:0] {
    CT_NONE   = 2'd0,
    CT_SDV1   = 2'd1,
    CT_SDV2   = 2'd2,
    CT_SDHCV2 = 2'd3
  } card_type_e;

  typedef enum logic [2:0] {
    ST_WAIT_RDY  = 3'd0,
    ST_ARB       = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_FINISH    = 3'd5
  } arb_state_e;

  localparam logic [9:0] SECTOR_BYTES = 10'd512;

endpackage

// File: rtl/sd_sector_read_arbiter_if.sv
// Command/stream port of the SPI sector reader, as seen by its single owner.
interface sd_sector_read_arbiter_if;
  // start is a one-cycle pulse with sector_no valid in the same cycle; the
  // reader answers with rvalid-qualified bytes (raddr/rdata) and a done pulse.
  // There is no back-pressure: every rvalid byte must be taken that cycle.
  logic        start;
  logic [31:0] sector_no;
  logic        done;
  logic        rvalid;
  logic [8:0]  raddr;
  logic [7:0]  rdata;
  logic [3:0]  card_stat;

  modport master (output start, sector_no, input done, rvalid, raddr, rdata, card_stat);
  modport slave  (input start, sector_no, output done, rvalid, raddr, rdata, card_stat);
endinterface

// File: rtl/sd_sector_read_arbiter_grant.sv
// Two-input round-robin grant; after a served pulse the other requester wins ties.
module sd_rr_grant2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       served,
  input  logic       served_id,
  output logic       grant_valid,
  output logic       grant_id
);
  logic prefer_b;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) prefer_b <= 1'b0;
    else if (served) prefer_b <= ~served_id;
  end

  always_comb begin
    grant_valid = |req;
    grant_id    = 1'b0;
    if (req == 2'b10) grant_id = 1'b1;
    else if (req == 2'b11) grant_id = prefer_b;
  end
endmodule

// File: rtl/sd_sector_read_arbiter.sv
// Round-robin scheduler of multi-sector read jobs from two requesters onto the
// single-sector SPI reader, with byte-stream steering and error reporting.
module sd_sector_read_arbiter
  import sd_sector_read_arbiter_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
  parameter logic [7:0]  ISSUE_WAIT     = 8'd4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        a_req,
  input  logic [31:0] a_sector,
  input  logic [15:0] a_count,
  output logic        a_ack,
  output logic        a_done,
  output logic        a_err,
  input  logic        b_req,
  input  logic [31:0] b_sector,
  input  logic [15:0] b_count,
  output logic        b_ack,
  output logic        b_done,
  output logic        b_err,
  output logic        out_valid,
  output logic        out_id,
  output logic [15:0] out_sidx,
  output logic [8:0]  out_addr,
  output logic [7:0]  out_data,
  sd_sector_read_arbiter_if.master rd,
  output logic        busy,
  output arb_state_e  dbg_state
);
  arb_state_e  state, state_nxt;
  logic        owner, job_active, err_acc;
  logic [31:0] base;
  logic [15:0] count, sidx;
  logic [9:0]  byte_cnt, byte_cnt_eff;
  logic [23:0] tmo_cnt;
  logic [7:0]  wait_cnt;
  logic        start_q;
  logic [31:0] sector_q;
  logic        grant_valid, grant_id, grant_zero;
  logic        stat_idle, done_ok, last_sector, timed_out;

  assign rd.start     = start_q;
  assign rd.sector_no = sector_q;
  assign dbg_state    = state;

  sd_rr_grant2 u_grant (
    .clk         (clk),
    .rstn        (rstn),
    .req         ({b_req, a_req}),
    .served      (state == ST_FINISH),
    .served_id   (owner),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign stat_idle   = (rd.card_stat == CS_IDLE);
  assign done_ok     = rd.done && (wait_cnt >= ISSUE_WAIT);
  assign last_sector = ((sidx + 16'd1) == count);
  assign timed_out   = (tmo_cnt >= TIMEOUT_CYCLES - 24'd1);
  assign grant_zero  = ((grant_id ? b_count : a_count) == 16'd0);
  // A byte arriving with done is counted before the short-sector test.
  assign byte_cnt_eff = (rd.rvalid && byte_cnt != SECTOR_BYTES) ? byte_cnt + 10'd1 : byte_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_WAIT_RDY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT_RDY:  if (stat_idle) state_nxt = job_active ? ST_ISSUE : ST_ARB;
      ST_ARB:       if (grant_valid) state_nxt = grant_zero ? ST_FINISH : ST_ISSUE;
      ST_ISSUE:     state_nxt = stat_idle ? ST_WAIT_DONE : ST_WAIT_RDY;
      ST_WAIT_DONE: begin
        if (done_ok)        state_nxt = last_sector ? ST_FINISH : ST_ISSUE;
        else if (timed_out) state_nxt = ST_DRAIN;
      end
      ST_DRAIN:     if (stat_idle || rd.done) state_nxt = ST_FINISH;
      ST_FINISH:    state_nxt = ST_ARB;
      default:      state_nxt = ST_WAIT_RDY;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_ack <= 1'b0; a_done <= 1'b0; a_err <= 1'b0;
      b_ack <= 1'b0; b_done <= 1'b0; b_err <= 1'b0;
      out_valid <= 1'b0; out_id <= 1'b0; out_sidx <= '0; out_addr <= '0; out_data <= '0;
      start_q <= 1'b0; sector_q <= '0; busy <= 1'b0;
      owner <= 1'b0; job_active <= 1'b0; err_acc <= 1'b0;
      base <= '0; count <= '0; sidx <= '0;
      byte_cnt <= '0; tmo_cnt <= '0; wait_cnt <= '0;
    end else begin
      a_ack <= 1'b0; a_done <= 1'b0; a_err <= 1'b0;
      b_ack <= 1'b0; b_done <= 1'b0; b_err <= 1'b0;
      out_valid <= 1'b0;
      start_q   <= 1'b0;
      busy      <= (state_nxt != ST_ARB);
      case (state)
        ST_ARB: if (grant_valid) begin
          owner      <= grant_id;
          job_active <= 1'b1;
          base       <= grant_id ? b_sector : a_sector;
          count      <= grant_id ? b_count : a_count;
          err_acc    <= 1'b0;
          sidx       <= '0;
          a_ack      <= ~grant_id;
          b_ack      <= grant_id;
        end
        ST_ISSUE: if (stat_idle) begin
          start_q  <= 1'b1;
          sector_q <= base + {16'd0, sidx};
          byte_cnt <= '0;
          tmo_cnt  <= '0;
          wait_cnt <= '0;
        end
        ST_WAIT_DONE: begin
          if (rd.rvalid) begin
            out_valid <= 1'b1;
            out_addr  <= rd.raddr;
            out_data  <= rd.rdata;
            out_id    <= owner;
            out_sidx  <= sidx;
          end
          byte_cnt <= byte_cnt_eff;
          if (wait_cnt < ISSUE_WAIT) wait_cnt <= wait_cnt + 8'd1;
          if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 24'd1;
          if (done_ok) begin
            if (byte_cnt_eff != SECTOR_BYTES) err_acc <= 1'b1;
            sidx <= sidx + 16'd1;
          end else if (timed_out) begin
            err_acc <= 1'b1;
          end
        end
        ST_FINISH: begin
          a_done     <= ~owner;
          b_done     <= owner;
          a_err      <= ~owner & err_acc;
          b_err      <= owner & err_acc;
          job_active <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_sector_read_arbiter.sv
// Directed bench: a reader model answers every start, a negedge monitor scores
// sectors and bytes, and a job table plus hand sequences cover the corners.
module tb_sd_sector_read_arbiter;
  import sd_sector_read_arbiter_pkg::*;

  typedef struct {
    logic        id;
    logic [31:0] sector;
    int          count;
    int          len;
    bit          done_en;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic a_req = 1'b0, b_req = 1'b0;
  logic [31:0] a_sector = '0, b_sector = '0;
  logic [15:0] a_count = '0, b_count = '0;
  logic a_ack, a_done, a_err, b_ack, b_done, b_err;
  logic out_valid, out_id, busy;
  logic [15:0] out_sidx;
  logic [8:0] out_addr;
  logic [7:0] out_data;
  arb_state_e dbg_state;

  logic [3:0] stat_base = 4'd3;
  logic m_reading = 1'b0, m_done = 1'b0, m_rvalid = 1'b0;
  logic [8:0] m_raddr = '0;
  logic [7:0] m_rdata = '0;
  int model_len = 512;
  bit model_done_en = 1'b1;

  int n_vec = 0, n_err = 0;
  int cyc = 0, n_ack = 0, n_done = 0, n_start = 0;
  int job_starts = 0, job_bytes = 0, byte_idx = 0, cur_sidx = 0;
  int ack_cyc = 0, done_cyc = 0;
  logic cur_owner = 1'b0, last_done_id = 1'b0, last_err = 1'b0;
  logic [31:0] exp_q[$];
  logic ack_ids[$];

  sd_sector_read_arbiter_if rd_bus ();
  assign rd_bus.card_stat = m_reading ? 4'd9 : stat_base;
  assign rd_bus.done      = m_done;
  assign rd_bus.rvalid    = m_rvalid;
  assign rd_bus.raddr     = m_raddr;
  assign rd_bus.rdata     = m_rdata;

  sd_sector_read_arbiter #(.TIMEOUT_CYCLES(24'd1000), .ISSUE_WAIT(8'd4)) dut (
    .clk(clk), .rstn(rstn),
    .a_req(a_req), .a_sector(a_sector), .a_count(a_count),
    .a_ack(a_ack), .a_done(a_done), .a_err(a_err),
    .b_req(b_req), .b_sector(b_sector), .b_count(b_count),
    .b_ack(b_ack), .b_done(b_done), .b_err(b_err),
    .out_valid(out_valid), .out_id(out_id), .out_sidx(out_sidx),
    .out_addr(out_addr), .out_data(out_data),
    .rd(rd_bus), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reader model: every start yields model_len bytes, then done or a hang
  initial forever begin
    @(negedge clk);
    if (rd_bus.start === 1'b1) begin
      m_reading = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < model_len; i++) begin
        m_rvalid = 1'b1;
        m_raddr  = 9'(i);
        m_rdata  = 8'(i) ^ 8'h5A;
        @(negedge clk);
      end
      m_rvalid = 1'b0;
      if (model_done_en) begin
        m_done = 1'b1;
        m_reading = 1'b0;
        @(negedge clk);
        m_done = 1'b0;
      end else begin
        repeat (1500) @(negedge clk);
        m_reading = 1'b0;
      end
    end
  end

  // scoreboard / monitor
  initial forever begin
    @(negedge clk);
    if (a_ack || b_ack) begin
      n_ack++;
      cur_owner = b_ack;
      job_starts = 0;
      ack_ids.push_back(b_ack);
      ack_cyc = cyc;
    end
    if (rd_bus.start) begin
      n_start++;
      byte_idx = 0;
      cur_sidx = job_starts;
      job_starts++;
      if (exp_q.size() == 0) chk("unexpected_start", 32'd1, 32'd0);
      else chk("start_sector", rd_bus.sector_no, exp_q.pop_front());
    end
    if (out_valid) begin
      chk("byte_tag", {15'd0, out_id, out_sidx}, {15'd0, cur_owner, 16'(cur_sidx)});
      chk("byte_val", {15'd0, out_addr, out_data}, {15'd0, byte_idx[8:0], byte_idx[7:0] ^ 8'h5A});
      byte_idx++;
      job_bytes++;
    end
    if (a_done || b_done) begin
      n_done++;
      last_done_id = b_done;
      last_err = b_done ? b_err : a_err;
      done_cyc = cyc;
    end
  end

  // driver task: one job from one requester, checked end to end
  task automatic run_job(input vec_t v);
    int base_ack, base_done, t;
    @(negedge clk);
    model_len = v.len;
    model_done_en = v.done_en;
    for (int k = 0; k < v.count; k++) exp_q.push_back(v.sector + 32'(k));
    job_bytes = 0;
    base_ack = n_ack;
    base_done = n_done;
    if (v.id == 1'b0) begin
      a_sector = v.sector; a_count = 16'(v.count); a_req = 1'b1;
    end else begin
      b_sector = v.sector; b_count = 16'(v.count); b_req = 1'b1;
    end
    t = 0;
    while (n_ack == base_ack && t < 50) begin @(posedge clk); t++; end
    @(negedge clk);
    a_req = 1'b0;
    b_req = 1'b0;
    chk("job_ack", 32'(n_ack - base_ack), 32'd1);
    t = 0;
    while (n_done == base_done && t < 20000) begin @(posedge clk); t++; end
    @(posedge clk);
    chk("job_done", 32'(n_done - base_done), 32'd1);
    chk("done_id", {31'd0, last_done_id}, {31'd0, v.id});
    chk("done_err", {31'd0, last_err}, {31'd0, v.exp_err});
    chk("job_bytes", 32'(job_bytes), 32'(v.count * v.len));
    chk("job_starts", 32'(job_starts), 32'(v.count));
    chk("sectors_left", 32'(exp_q.size()), 32'd0);
    if (v.count == 0) chk("ack_to_done", 32'(done_cyc - ack_cyc), 32'd1);
  endtask

  vec_t vecs[8];

  initial begin
    int t, i, base_done, bytes_at_rst;
    vecs[0] = '{1'b0, 32'h0000_0010, 3, 512, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0200, 2, 512, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF, 2, 512, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0040, 1, 300, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 32'h0000_0050, 1, 300, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 32'h0000_0060, 0, 512, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_0070, 1, 512, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 32'h0000_0080, 1, 512, 1'b0, 1'b1};

    // reset values, then card not ready while A requests
    a_req = 1'b1; a_sector = 32'h10; a_count = 16'd1;
    repeat (3) @(negedge clk);
    chk("rst_flags", {22'd0, a_ack, a_done, a_err, b_ack, b_done, b_err, out_valid, out_id, busy, rd_bus.start}, 32'd0);
    chk("rst_bytes", {15'd0, out_addr, out_data}, 32'd0);
    chk("rst_sidx", {16'd0, out_sidx}, 32'd0);
    chk("rst_sector_no", rd_bus.sector_no, 32'd0);
    rstn = 1'b1;
    repeat (1000) @(posedge clk);
    chk("notready_ack", 32'(n_ack), 32'd0);
    chk("notready_start", 32'(n_start), 32'd0);
    exp_q.push_back(32'h10);
    base_done = n_done;
    @(negedge clk);
    stat_base = 4'd8;
    i = 0;
    while (!a_ack && i < 10) begin @(negedge clk); i++; end
    a_req = 1'b0;
    chk("ack_latency_le2", {31'd0, i <= 2}, 32'd1);
    t = 0;
    while (n_done == base_done && t < 5000) begin @(posedge clk); t++; end
    @(posedge clk);
    chk("first_done", 32'(n_done - base_done), 32'd1);
    chk("first_err", {31'd0, last_err}, 32'd0);
    chk("first_sectors_left", 32'(exp_q.size()), 32'd0);

    for (int k = 0; k < 8; k++) run_job(vecs[k]);

    // fresh reset: both requesters held, strict alternation starting with A
    @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    ack_ids.delete();
    model_len = 512; model_done_en = 1'b1;
    a_sector = 32'h100; a_count = 16'd1;
    b_sector = 32'h200; b_count = 16'd1;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(32'h100);
      exp_q.push_back(32'h200);
    end
    base_done = n_done;
    a_req = 1'b1; b_req = 1'b1;
    t = 0;
    while (ack_ids.size() < 4 && t < 20000) begin @(posedge clk); t++; end
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0;
    t = 0;
    while (n_done - base_done < 4 && t < 5000) begin @(posedge clk); t++; end
    chk("alt_acks", 32'(ack_ids.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      chk("alt_order", {31'd0, (k < ack_ids.size()) ? ack_ids[k] : 1'bx}, 32'(k % 2));
    chk("alt_dones", 32'(n_done - base_done), 32'd4);
    chk("alt_sectors_left", 32'(exp_q.size()), 32'd0);

    // reset in the middle of a sector: outputs clear at once, job is lost
    repeat (5) @(negedge clk);
    exp_q.push_back(32'h300);
    job_bytes = 0;
    a_sector = 32'h300; a_count = 16'd2;
    a_req = 1'b1;
    t = 0;
    while (job_bytes < 10 && t < 200) begin @(posedge clk); t++; end
    a_req = 1'b0;
    @(negedge clk);
    base_done = n_done;
    rstn = 1'b0;
    #1;
    chk("midrst_flags", {22'd0, a_ack, a_done, a_err, b_ack, b_done, b_err, out_valid, out_id, busy, rd_bus.start}, 32'd0);
    chk("midrst_bytes", {15'd0, out_addr, out_data}, 32'd0);
    chk("midrst_sector_no", rd_bus.sector_no, 32'd0);
    chk("midrst_state", {29'd0, dbg_state}, {29'd0, ST_WAIT_RDY});
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd1);
    bytes_at_rst = job_bytes;
    repeat (1000) @(posedge clk);
    chk("midrst_no_done", 32'(n_done - base_done), 32'd0);
    chk("midrst_no_fwd", 32'(job_bytes), 32'(bytes_at_rst));
    chk("midrst_state_arb", {29'd0, dbg_state}, {29'd0, ST_ARB});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
